seg_scan_mux: RTL and testbench

Time-multiplexed scanner for the washing-machine multi-digit LED display. Holds NUM_DIGITS BCD digits and steps through them at a fixed refresh rate. Each slot presents one 4-bit digit code to the downstream BCD-to-7-segment decoder and drives the matching active-low anode. Digit updates are double-buffered so a frame never shows a mix of old and new values. The block also provides an anti-ghosting guard and optional leading-zero blanking.

---
 rtl/seg_scan_mux_pkg.sv | 20 ++
 rtl/seg_scan_mux_if.sv | 34 +++
 rtl/seg_refresh_div.sv | 50 +++++
 rtl/seg_scan_mux.sv | 127 ++++++++++++
 tb/tb_seg_scan_mux.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_mux_pkg.sv
// seg_scan_mux_pkg
// Shared definitions for the multi-digit LED display scanner: the BCD digit
// width, default board-clock timing values and the counter-width helper.
// No ports (package).
package seg_scan_mux_pkg;

  localparam int BCD_W = 4;

  // Defaults for the board clock: 50000 cycles per digit slot, of which the
  // first 500 keep every anode dark so the previous digit cannot ghost.
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIV        = 50000;
  localparam int DEF_GUARD      = 500;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if
// Bundles the control, digit data and display-drive signals of the scanner.
//   enable     : scan enable; low blanks the display and parks at slot 0
//   load       : one-cycle strobe capturing digits_in into the pending buffer
//   digits_in  : BCD digits, [3:0] is digit 0 (rightmost)
//   lz_en      : leading-zero suppression enable
//   digit_code : BCD code of the slot currently shown
//   an_n       : active-low anode selects, bit i lights digit i
//   frame_done : one-cycle pulse after each complete frame
// master: the controller side; slave: the scanner.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = seg_scan_mux_pkg::DEF_NUM_DIGITS
);
  import seg_scan_mux_pkg::*;

  logic                          enable;
  logic                          load;
  logic [BCD_W*NUM_DIGITS-1:0]   digits_in;
  logic                          lz_en;
  logic [BCD_W-1:0]              digit_code;
  logic [NUM_DIGITS-1:0]         an_n;
  logic                          frame_done;

  modport master (
    output enable, load, digits_in, lz_en,
    input  digit_code, an_n, frame_done
  );

  modport slave (
    input  enable, load, digits_in, lz_en,
    output digit_code, an_n, frame_done
  );

endinterface

// File: rtl/seg_refresh_div.sv
// seg_refresh_div
// Slot prescaler for the display scanner. Counts DIV clocks per digit slot.
//   clk, rst_n : clock and asynchronous active-low reset
//   enable     : counts while high; low forces the count back to 0
//   tick       : high in the cycle whose edge ends the current slot
//   guard_next : high when the count after the coming edge lies inside the
//                anode-off guard window at the start of a slot
// Both outputs look one edge ahead so the scanner can register its outputs
// against the post-edge slot position.
module seg_refresh_div
  import seg_scan_mux_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int GUARD = DEF_GUARD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick,
  output logic guard_next
);

  localparam int            CW      = clog2_min1(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW:0]   GUARD_C = (CW + 1)'(GUARD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next count: wraps at the end of a slot and is held at zero while the
  // scanner is disabled so re-enabling always starts a full slot.
  always_comb begin
    tick = enable && (cnt == CNT_MAX);
    if (!enable || (cnt == CNT_MAX)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
    guard_next = ({1'b0, cnt_next} < GUARD_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux
// Time-multiplexed scanner for the multi-digit LED display. Steps through
// NUM_DIGITS BCD digits, one per slot of DIV clocks, presenting each digit's
// code to the segment decoder and pulling its anode low after a GUARD-cycle
// blanking window. New digit values are double-buffered and only swapped in
// at a frame boundary, so a frame never mixes old and new digits.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : seg_scan_mux_if.slave (enable, load, digits_in, lz_en in;
//                digit_code, an_n, frame_done out, all registered)
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIV        = DEF_DIV,
  parameter int GUARD      = DEF_GUARD
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_mux_if.slave      bus
);

  localparam int            IW      = clog2_min1(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_t;

  logic                  tick;
  logic                  guard_next;
  logic                  boundary;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  digits_t               active;
  digits_t               active_next;
  digits_t               pending;
  logic                  pending_valid;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] an_next;
  logic [BCD_W-1:0]      digit_code_q;
  logic [NUM_DIGITS-1:0] an_n_q;
  logic                  frame_done_q;

  seg_refresh_div #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (bus.enable),
    .tick       (tick),
    .guard_next (guard_next)
  );

  // Slot index and displayed-digit selection for the coming edge. A load that
  // coincides with the frame boundary bypasses the pending buffer so the new
  // value is visible from slot 0 of the new frame.
  always_comb begin
    boundary = tick && (idx == IDX_MAX);
    idx_next = idx;
    if (!bus.enable) begin
      idx_next = '0;
    end else if (tick) begin
      idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
    active_next = active;
    if (boundary && bus.load) begin
      active_next = bus.digits_in;
    end else if (boundary && pending_valid) begin
      active_next = pending;
    end
  end

  // Leading-zero mask: walking down from the most significant digit, a digit
  // stays dark while it and every digit above it are zero. Digit 0 is never
  // part of the walk, so a value of all zeros still shows a single 0.
  always_comb begin
    all_zero = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero    = all_zero && (active_next[i] == '0);
      suppress[i] = bus.lz_en && all_zero;
    end
  end

  // Anode pattern for the coming edge: dark while disabled, during the guard
  // window, or when the digit is a suppressed leading zero.
  always_comb begin
    an_next = '1;
    if (bus.enable && !guard_next && !suppress[idx_next]) begin
      an_next[idx_next] = 1'b0;
    end
  end

  // Scanner state and registered display outputs. The pending flag clears on
  // every boundary because either the pending value or a same-edge load has
  // just been taken into the active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      digit_code_q  <= '0;
      an_n_q        <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      idx    <= idx_next;
      active <= active_next;
      if (bus.load) begin
        pending <= bus.digits_in;
      end
      if (boundary) begin
        pending_valid <= 1'b0;
      end else if (bus.load) begin
        pending_valid <= 1'b1;
      end
      digit_code_q <= active_next[idx_next];
      an_n_q       <= an_next;
      frame_done_q <= boundary;
    end
  end

  assign bus.digit_code = digit_code_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux
// Scoreboard bench for seg_scan_mux with NUM_DIGITS=4, DIV=8, GUARD=2 (one
// frame = 32 cycles). The stimulus process queues hand-computed display states
// tagged with the cycle they must appear in; the monitor compares them on the
// falling edge of that cycle.
module tb_seg_scan_mux;
  import seg_scan_mux_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] code;
    logic [3:0] an;
    logic       fd;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   base;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];
  exp_t e;

  seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS (4),
    .DIV        (8),
    .GUARD      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and rising-edge count used to tag expectations.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Advance to just after the k-th rising edge counted from base.
  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse load with val so it is captured by edge k.
  task automatic apply_stimulus(input int k, input logic [15:0] val);
    goto(k - 1);
    bus.load      = 1'b1;
    bus.digits_in = val;
    goto(k);
    bus.load      = 1'b0;
  endtask

  // Queue the display state required after edge k.
  task automatic check_output(input int k, input logic [3:0] code,
                              input logic [3:0] an, input logic fd,
                              input string name);
    exp_t x;
    x.cyc  = base + k;
    x.code = code;
    x.an   = an;
    x.fd   = fd;
    x.name = name;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every expectation due in this cycle away from the edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (e.cyc < cyc) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s: check due at cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (bus.digit_code !== e.code || bus.an_n !== e.an || bus.frame_done !== e.fd) begin
        miscompares = miscompares + 1;
        $display("[TB] FAIL %s: got code=%h an_n=%b fd=%b, expected code=%h an_n=%b fd=%b",
                 e.name, bus.digit_code, bus.an_n, bus.frame_done, e.code, e.an, e.fd);
      end
    end
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: time limit reached, %0d checks still queued", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    base          = 0;
    rst_n         = 1'b1;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.lz_en     = 1'b0;
    bus.digits_in = '0;
    #1 rst_n = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    check_output(cyc - base, 4'h0, 4'b1111, 1'b0, "reset");
    @(posedge clk); #1;

    // Bring-up: 1234 is pending through the first frame, shown from the next.
    rst_n         = 1'b1;
    bus.enable    = 1'b1;
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    base          = cyc;
    check_output(1,  4'h0, 4'b1111, 1'b0, "first_guard");
    check_output(2,  4'h0, 4'b1110, 1'b0, "first_s0");
    check_output(10, 4'h0, 4'b1101, 1'b0, "first_s1");
    check_output(32, 4'h4, 4'b1111, 1'b1, "f1_s0_guard_fd");
    check_output(33, 4'h4, 4'b1111, 1'b0, "f1_s0_guard2");
    check_output(34, 4'h4, 4'b1110, 1'b0, "f1_s0_lit");
    check_output(39, 4'h4, 4'b1110, 1'b0, "f1_s0_end");
    check_output(40, 4'h3, 4'b1111, 1'b0, "f1_s1_guard");
    check_output(42, 4'h3, 4'b1101, 1'b0, "f1_s1");
    check_output(50, 4'h2, 4'b1011, 1'b0, "f1_s2");
    check_output(58, 4'h1, 4'b0111, 1'b0, "f1_s3");
    check_output(64, 4'h4, 4'b1111, 1'b1, "f2_fd");
    check_output(65, 4'h4, 4'b1111, 1'b0, "f2_fd_low");
    goto(1);
    bus.load = 1'b0;

    // Atomic update: mid-frame load waits for the boundary; latest load wins.
    check_output(83,  4'h2, 4'b1011, 1'b0, "upd_old_s2");
    check_output(90,  4'h1, 4'b0111, 1'b0, "upd_old_s3");
    check_output(96,  4'h8, 4'b1111, 1'b1, "upd_new_fd");
    check_output(98,  4'h8, 4'b1110, 1'b0, "upd_5678_s0");
    check_output(101, 4'h8, 4'b1110, 1'b0, "upd_hold_s0");
    check_output(106, 4'h7, 4'b1101, 1'b0, "upd_5678_s1");
    check_output(114, 4'h6, 4'b1011, 1'b0, "upd_5678_s2");
    check_output(122, 4'h5, 4'b0111, 1'b0, "upd_5678_s3");
    check_output(130, 4'h1, 4'b1110, 1'b0, "upd_4321_s0");
    check_output(138, 4'h2, 4'b1101, 1'b0, "upd_4321_s1");
    check_output(146, 4'h3, 4'b1011, 1'b0, "upd_4321_s2");
    check_output(154, 4'h4, 4'b0111, 1'b0, "upd_4321_s3");
    apply_stimulus(83, 16'h5678);
    apply_stimulus(100, 16'h9999);
    apply_stimulus(110, 16'h4321);

    // Load on the boundary edge goes straight to the active set.
    check_output(160, 4'hD, 4'b1111, 1'b1, "bnd_s0_guard");
    check_output(162, 4'hD, 4'b1110, 1'b0, "bnd_s0");
    check_output(170, 4'hC, 4'b1101, 1'b0, "bnd_s1");
    check_output(178, 4'hB, 4'b1011, 1'b0, "bnd_s2");
    check_output(186, 4'hA, 4'b0111, 1'b0, "bnd_s3");
    apply_stimulus(160, 16'hABCD);

    // Leading-zero suppression on 0050, then 0000.
    check_output(192, 4'h0, 4'b1111, 1'b1, "lz_fd");
    check_output(194, 4'h0, 4'b1110, 1'b0, "lz_s0_zero");
    check_output(202, 4'h5, 4'b1101, 1'b0, "lz_s1_five");
    check_output(210, 4'h0, 4'b1111, 1'b0, "lz_s2_dark");
    check_output(218, 4'h0, 4'b1111, 1'b0, "lz_s3_dark");
    check_output(226, 4'h0, 4'b1110, 1'b0, "lz0_s0");
    check_output(234, 4'h0, 4'b1111, 1'b0, "lz0_s1");
    check_output(242, 4'h0, 4'b1111, 1'b0, "lz0_s2");
    check_output(250, 4'h0, 4'b1111, 1'b0, "lz0_s3");
    goto(164);
    bus.lz_en = 1'b1;
    apply_stimulus(165, 16'h0050);
    apply_stimulus(200, 16'h0000);

    // Enable drop in slot 2 at cnt 5, pending load while disabled, re-enable.
    check_output(258, 4'h1, 4'b1110, 1'b0, "en_s0");
    check_output(277, 4'h3, 4'b1011, 1'b0, "en_before_drop");
    check_output(278, 4'h1, 4'b1111, 1'b0, "en_dropped");
    check_output(288, 4'h1, 4'b1111, 1'b0, "en_no_fd");
    check_output(291, 4'h1, 4'b1111, 1'b0, "re_guard1");
    check_output(292, 4'h1, 4'b1110, 1'b0, "re_s0_lit");
    check_output(300, 4'h2, 4'b1101, 1'b0, "re_s1_old");
    check_output(322, 4'h5, 4'b1111, 1'b1, "re_xfer_fd");
    check_output(324, 4'h5, 4'b1110, 1'b0, "re_8765_s0");
    check_output(332, 4'h6, 4'b1101, 1'b0, "re_8765_s1");
    check_output(333, 4'h0, 4'b1111, 1'b0, "async_reset");
    apply_stimulus(240, 16'h4321);
    goto(255);
    bus.lz_en = 1'b0;
    goto(277);
    bus.enable = 1'b0;
    apply_stimulus(284, 16'h8765);
    goto(290);
    bus.enable = 1'b1;

    // Asynchronous reset between edges in slot 1 drops the pending 1111.
    apply_stimulus(332, 16'h1111);
    goto(333);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base  = cyc;
    check_output(1,  4'h0, 4'b1111, 1'b0, "post_rst_guard");
    check_output(2,  4'h0, 4'b1110, 1'b0, "post_rst_s0");
    check_output(32, 4'h0, 4'b1111, 1'b1, "post_rst_no_pending");
    check_output(34, 4'h0, 4'b1110, 1'b0, "post_rst_s0_lit");
    goto(36);
    @(negedge clk); #1;

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: never checked (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
